instr_encoder: RTL and testbench

- Inverse of the main/ALU control decode path: takes field-level instruction requests (format, opcode, funct3, funct7b5, register numbers, immediate) and packs them into RV32I machine words.
- Encoded words are buffered and streamed, with an auto-incrementing byte address, to an instruction-memory write port.
- Used as the boot/program loader in front of imem, and as the stimulus generator for pipeline test benches.

---
 rtl/riscv_pkg.sv | 57 +++++
 rtl/instr_fifo.sv | 67 ++++++
 rtl/instr_encoder.sv | 163 ++++++++++++++++
 tb/tb_instr_encoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I field codes, opcode constants, encoder state type and the
// field-to-word packing function used by the instruction encoder.
package riscv_pkg;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } enc_state_e;

  // Formats 11x fall through to R so an unchecked build still emits a word.
  function automatic logic [31:0] encode_instr(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic        f7b5,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    logic [6:0]  hi7;
    hi7 = {1'b0, f7b5, 5'b00000};
    case (fmt)
      FMT_I: begin
        if (op == OP_ITYPE && (f3 == 3'b001 || f3 == 3'b101))
          w = {hi7, imm[4:0], rs1, f3, rd, op};
        else
          w = {imm[11:0], rs1, f3, rd, op};
      end
      FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      FMT_U:   w = {imm[31:12], rd, op};
      default: w = {hi7, rs2, rs1, f3, rd, op};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Show-ahead FIFO: head is valid whenever count is non-zero.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/instr_encoder.sv
// Packs field-level requests into RV32I words and streams them to imem.
// Define INSTR_ENCODER_CHECK_EN to reject illegal requests and raise err.
//
// state    | meaning
// ST_LOAD  | accepting requests
// ST_DRAIN | no new requests; flushing encode register and FIFO
// ST_DONE  | all words written; idle until restart or reset
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_fmt,
  input  logic [6:0]        req_op,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7b5,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W-1:0] words,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(DEPTH) + 1;

  enc_state_e        state_q, state_d;
  logic              enc_valid_q, enc_valid_d;
  logic [31:0]       enc_data_q, enc_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] words_q, words_d;

  logic [31:0]       fifo_head;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     occupancy;
  logic              accept, pop, push, drained_next, illegal;

  assign occupancy = fifo_count + CW'(enc_valid_q);
  assign accept    = req_valid && req_ready;
  assign wr_valid  = !fifo_empty;
  assign pop       = wr_valid && wr_ready && !restart;
  assign push      = enc_valid_q && !restart;
  // Empty after this edge: nothing in the encode register and the last
  // FIFO word (if any) leaves on this edge.
  assign drained_next = !enc_valid_q &&
                        ((fifo_count == '0) || (fifo_count == CW'(1) && pop));

  instr_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (restart),
    .push      (push),
    .push_data (enc_data_q),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:  if (finish) state_d = ST_DRAIN;
        ST_DRAIN: if (drained_next) state_d = ST_DONE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_LOAD;
      endcase
    end
  end

  always_comb begin
    req_ready = (state_q == ST_LOAD) && !restart && (occupancy < CW'(DEPTH));
    done      = (state_q == ST_DONE);
  end

`ifdef INSTR_ENCODER_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    case (req_fmt)
      FMT_I, FMT_S: illegal = (req_imm[31:11] != {21{req_imm[11]}});
      FMT_B:        illegal = req_imm[0] || (req_imm[31:12] != {20{req_imm[12]}});
      FMT_J:        illegal = req_imm[0] || (req_imm[31:20] != {12{req_imm[20]}});
      FMT_U, FMT_R: illegal = 1'b0;
      default:      illegal = 1'b1;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (restart)                 err_d = 1'b0;
    else if (accept && illegal)  err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    enc_valid_d = accept && !illegal;
    enc_data_d  = enc_data_q;
    if (accept)
      enc_data_d = encode_instr(req_fmt, req_op, req_funct3, req_funct7b5,
                                req_rd, req_rs1, req_rs2, req_imm);
    wr_addr_d = wr_addr_q;
    words_d   = words_q;
    if (restart) begin
      wr_addr_d = BASE_ADDR;
      words_d   = '0;
    end else if (pop) begin
      wr_addr_d = wr_addr_q + ADDR_W'(4);
      words_d   = words_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_valid_q <= 1'b0;
      enc_data_q  <= '0;
      wr_addr_q   <= BASE_ADDR;
      words_q     <= '0;
    end else begin
      enc_valid_q <= enc_valid_d;
      enc_data_q  <= enc_data_d;
      wr_addr_q   <= wr_addr_d;
      words_q     <= words_d;
    end
  end

  assign wr_addr = wr_addr_q;
  assign words   = words_q;
  assign wr_data = fifo_empty ? 32'h0 : fifo_head;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized plus directed bench for instr_encoder with a queue-based model.
module tb_instr_encoder;
  import riscv_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk, rst_n, restart, finish, req_valid, req_ready;
  logic [2:0]  req_fmt, req_funct3;
  logic [6:0]  req_op;
  logic        req_funct7b5;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        wr_valid, wr_ready, done, err;
  logic [31:0] wr_addr, wr_data, words;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
    .req_op(req_op), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .words(words), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built by shifting each field into its bit position.
  function automatic logic [31:0] ref_word(input int unsigned fmt, input int unsigned op,
      input int unsigned f3, input int unsigned f7, input int unsigned rd,
      input int unsigned rs1, input int unsigned rs2, input logic [31:0] imm);
    int unsigned im, w, base_rr;
    im = imm;
    base_rr = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 30);
    case (fmt)
      0: begin
        if (op == 32'h13 && (f3 == 1 || f3 == 5))
          w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((im & 31) << 20) | (f7 << 30);
        else
          w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((im & 32'hFFF) << 20);
      end
      1: w = op | ((im & 31) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
             | (((im >> 5) & 127) << 25);
      2: w = op | (((im >> 11) & 1) << 7) | (((im >> 1) & 15) << 8) | (f3 << 12)
             | (rs1 << 15) | (rs2 << 20) | (((im >> 5) & 63) << 25) | (((im >> 12) & 1) << 31);
      3: w = op | (rd << 7) | (((im >> 12) & 255) << 12) | (((im >> 11) & 1) << 20)
             | (((im >> 1) & 1023) << 21) | (((im >> 20) & 1) << 31);
      4: w = op | (rd << 7) | (im & 32'hFFFFF000);
      default: w = base_rr;
    endcase
    return w;
  endfunction

  function automatic bit ref_illegal(input int unsigned fmt, input logic [31:0] imm);
`ifdef INSTR_ENCODER_CHECK_EN
    int s;
    s = $signed(imm);
    case (fmt)
      0, 1:    return (s < -2048 || s > 2047);
      2:       return imm[0] || s < -4096 || s > 4095;
      3:       return imm[0] || s < -1048576 || s > 1048575;
      4, 5:    return 1'b0;
      default: return 1'b1;
    endcase
`else
    return (fmt > 7);
`endif
  endfunction

  // Model state: 0 = loading, 1 = draining, 2 = done.
  logic [31:0] m_q[$];
  bit          m_encv, m_err, m_ready;
  logic [31:0] m_encw, m_addr, m_words;
  int          m_state;

  task automatic model_reset();
    m_q.delete();
    m_encv = 0; m_encw = 0; m_err = 0; m_addr = BASE; m_words = 0; m_state = 0;
  endtask

  initial begin
    bit acc, pop;
    model_reset();
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        model_reset();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, BASE);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_words", words, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
      end else begin
        m_ready = (m_state == 0) && !restart && (m_q.size() + int'(m_encv) < DEPTH);
        chk("req_ready", req_ready, m_ready);
        chk("wr_valid", wr_valid, m_q.size() > 0);
        chk("wr_data", wr_data, (m_q.size() > 0) ? m_q[0] : 32'h0);
        chk("wr_addr", wr_addr, m_addr);
        chk("words", words, m_words);
        chk("done", done, m_state == 2);
        chk("err", err, m_err);
        acc = req_valid && m_ready;
        pop = (m_q.size() > 0) && wr_ready && !restart;
        if (restart) begin
          model_reset();
        end else begin
          if (pop) begin
            void'(m_q.pop_front());
            m_addr  = m_addr + 4;
            m_words = m_words + 1;
          end
          if (m_encv) m_q.push_back(m_encw);
          m_encv = 0;
          if (acc) begin
            if (ref_illegal(req_fmt, req_imm)) m_err = 1;
            else begin
              m_encv = 1;
              m_encw = ref_word(req_fmt, req_op, req_funct3, req_funct7b5,
                                req_rd, req_rs1, req_rs2, req_imm);
            end
          end
          if (m_state == 0 && finish) m_state = 1;
          else if (m_state == 1 && m_q.size() == 0 && !m_encv) m_state = 2;
        end
      end
    end
  end

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
      input logic f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm);
    int k;
    @(negedge clk);
    finish = 0; restart = 0;
    req_fmt = fmt; req_op = op; req_funct3 = f3; req_funct7b5 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_valid = 1;
    #1;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk); #1; k++;
    end
    if (k == 50) chk("send_timeout", req_ready, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 0; finish = 0; restart = 0;
    end
  endtask

  task automatic do_restart();
    @(negedge clk);
    req_valid = 0; finish = 0; restart = 1;
    @(negedge clk);
    restart = 0;
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (!done && k < limit) begin
      @(negedge clk); #1; k++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic rand_fields();
    logic [6:0] ops [8];
    ops = '{OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};
    req_fmt = 3'($urandom_range(0, 7));
    req_op  = ($urandom_range(0, 4) == 0) ? 7'($urandom()) : ops[$urandom_range(0, 7)];
    req_funct3 = 3'($urandom()); req_funct7b5 = 1'($urandom());
    req_rd = 5'($urandom()); req_rs1 = 5'($urandom()); req_rs2 = 5'($urandom());
    if ($urandom_range(0, 1) == 0) req_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
    else                           req_imm = $urandom();
    if ($urandom_range(0, 1) == 0) req_imm[0] = 1'b0;
  endtask

  initial begin
    rst_n = 0; restart = 0; finish = 0; req_valid = 0; wr_ready = 1;
    req_fmt = 0; req_op = 0; req_funct3 = 0; req_funct7b5 = 0;
    req_rd = 0; req_rs1 = 0; req_rs2 = 0; req_imm = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;

    chk("ref_addi", ref_word(0, 7'h13, 0, 0, 1, 0, 0, 5), 32'h00500093);
    chk("ref_sub",  ref_word(5, 7'h33, 0, 1, 3, 1, 2, 0), 32'h402081B3);
    chk("ref_sw",   ref_word(1, 7'h23, 2, 0, 0, 1, 2, 12), 32'h0020A623);
    chk("ref_beq",  ref_word(2, 7'h63, 0, 0, 0, 1, 2, 8), 32'h00208463);
    chk("ref_jal",  ref_word(3, 7'h6F, 0, 0, 1, 0, 0, 16), 32'h010000EF);
    chk("ref_lui",  ref_word(4, 7'h37, 0, 0, 5, 0, 0, 32'h12345000), 32'h123452B7);
    chk("ref_srai", ref_word(0, 7'h13, 5, 1, 1, 2, 0, 3), 32'h40315093);

    // First-word latency: visible after the second edge.
    send(FMT_I, OP_ITYPE, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk); req_valid = 0; #3;
    chk("lat_edge1_wv", wr_valid, 0);
    @(negedge clk); #3;
    chk("lat_edge2_wv", wr_valid, 1);
    chk("lat_edge2_data", wr_data, 32'h00500093);
    chk("lat_edge2_addr", wr_addr, 32'h0);
    idle(3);

    do_restart();
    send(FMT_R, OP_RTYPE, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    send(FMT_S, OP_STORE, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd12);
    idle(5);
    chk("rs_words", words, 2);
    chk("rs_addr", wr_addr, 32'h8);

    // Back-pressure: four words fill encode register plus FIFO.
    do_restart();
    wr_ready = 0;
    send(FMT_B, OP_BRANCH, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    send(FMT_J, OP_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16);
    send(FMT_U, OP_LUI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    send(FMT_I, OP_ITYPE, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk); req_valid = 0; #3;
    chk("bp_ready_low", req_ready, 0);
    chk("bp_head", wr_data, 32'h00208463);
    idle(2);
    wr_ready = 1;
    idle(6);
    chk("bp_words", words, 4);

    // finish with three words queued.
    do_restart();
    wr_ready = 0;
    send(FMT_R, OP_RTYPE, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    send(FMT_S, OP_STORE, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd12);
    send(FMT_I, OP_ITYPE, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk); req_valid = 0; finish = 1;
    @(negedge clk); finish = 0; #3;
    chk("drain_ready", req_ready, 0);
    chk("drain_done", done, 0);
    idle(2);
    wr_ready = 1;
    wait_done(20);
    chk("fin_addr", wr_addr, 32'hC);
    chk("fin_words", words, 3);

    do_restart();
    #3;
    chk("rsd_addr", wr_addr, BASE);
    chk("rsd_words", words, 0);
    chk("rsd_wv", wr_valid, 0);
    chk("rsd_done", done, 0);

`ifdef INSTR_ENCODER_CHECK_EN
    send(FMT_B, OP_BRANCH, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7);
    idle(4);
    chk("chk_err", err, 1);
    chk("chk_words", words, 0);
    do_restart();
    #3;
    chk("chk_err_clr", err, 0);
`endif

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst_n     = (c != 200);
      rand_fields();
      req_valid = ($urandom_range(0, 9) < 6);
      wr_ready  = ($urandom_range(0, 9) < 7);
      finish    = ($urandom_range(0, 99) < 3);
      restart   = done ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) < 2);
    end
    @(negedge clk);
    rst_n = 1;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
